// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the 9-bit processor control unit:
// opcodes, FSM states and instruction field positions.
package proc_ctrl_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int RX_MSB = 5;
  localparam int RX_LSB = 3;
  localparam int RY_MSB = 2;
  localparam int RY_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F0,
    S_FW,
    S_F2,
    S_X1,
    S_XW,
    S_X2,
    S_X3
  } state_t;

endpackage

// File: rtl/dec3to8.sv
// One-hot 3-to-8 register decoder with enable.
// All outputs low when disabled.
module dec3to8 (
  input  logic       i_en,
  input  logic [2:0] i_sel,
  output logic [7:0] o_dec
);

  // Raise the selected bit only while enabled
  always_comb begin
    o_dec = '0;
    if (i_en) o_dec[i_sel] = 1'b1;
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Instruction fetch/decode/execute sequencer for the
// 9-bit processor; one instruction at a time.
module proc_control_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       MClock,
  input  logic       Resetn,
  input  logic       Run,
  input  logic [8:0] DIN,
  input  logic       GNZ,
  output logic       IRin,
  output logic [7:0] Rin,
  output logic [7:0] Rout,
  output logic       Gin,
  output logic       Gout,
  output logic       Ain,
  output logic       DINout,
  output logic       AddSub,
  output logic       ADDRin,
  output logic       DOUTin,
  output logic       W_D,
  output logic       incr_pc,
  output logic       Done,
  output logic       Busy
);

  localparam logic [1:0] LP_W = 2'(MEM_WAIT);

  state_t     r_state;
  state_t     w_next;
  logic [8:0] r_ir;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;
  logic       w_rin_en;
  logic       w_rout_en;
  logic [2:0] w_rin_sel;
  logic [2:0] w_rout_sel;
  logic [2:0] w_op;
  logic [2:0] w_rx;
  logic [2:0] w_ry;

  assign w_op = r_ir[OP_MSB:OP_LSB];
  assign w_rx = r_ir[RX_MSB:RX_LSB];
  assign w_ry = r_ir[RY_MSB:RY_LSB];

  // State, instruction register and wait counter
  always_ff @(posedge MClock or posedge Resetn) begin
    if (Resetn) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_F2) r_ir <= DIN;
    end
  end

  // Next state and control outputs from state and IR
  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_rin_en   = 1'b0;
    w_rout_en  = 1'b0;
    w_rin_sel  = w_rx;
    w_rout_sel = 3'd7;
    IRin       = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    Ain        = 1'b0;
    DINout     = 1'b0;
    AddSub     = 1'b0;
    ADDRin     = 1'b0;
    DOUTin     = 1'b0;
    W_D        = 1'b0;
    incr_pc    = 1'b0;
    Done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (Run) w_next = S_F0;
      end
      S_F0: begin
        w_rout_en = 1'b1;
        ADDRin    = 1'b1;
        incr_pc   = 1'b1;
        w_cnt_nxt = LP_W;
        w_next    = (LP_W == 2'd0) ? S_F2 : S_FW;
      end
      S_FW: begin
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt <= 2'd1) w_next = S_F2;
      end
      S_F2: begin
        DINout = 1'b1;
        IRin   = 1'b1;
        w_next = S_X1;
      end
      S_X1: begin
        unique case (w_op)
          OP_MV: begin
            w_rout_en  = 1'b1;
            w_rout_sel = w_ry;
            w_rin_en   = 1'b1;
            Done       = 1'b1;
          end
          OP_MVI: begin
            w_rout_en = 1'b1;
            ADDRin    = 1'b1;
            incr_pc   = 1'b1;
            w_cnt_nxt = LP_W;
            w_next    = (LP_W == 2'd0) ? S_X3 : S_XW;
          end
          OP_ADD, OP_SUB: begin
            w_rout_en  = 1'b1;
            w_rout_sel = w_rx;
            Ain        = 1'b1;
            w_next     = S_X2;
          end
          OP_LD: begin
            w_rout_en  = 1'b1;
            w_rout_sel = w_ry;
            ADDRin     = 1'b1;
            w_cnt_nxt  = LP_W;
            w_next     = (LP_W == 2'd0) ? S_X3 : S_XW;
          end
          OP_ST: begin
            w_rout_en  = 1'b1;
            w_rout_sel = w_ry;
            ADDRin     = 1'b1;
            w_next     = S_X2;
          end
          OP_MVNZ: begin
            w_rout_en  = GNZ;
            w_rout_sel = w_ry;
            w_rin_en   = GNZ;
            Done       = 1'b1;
          end
          OP_RSV: begin
            Done = 1'b1;
          end
          default: w_next = S_IDLE;
        endcase
      end
      S_XW: begin
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt <= 2'd1) w_next = S_X3;
      end
      S_X2: begin
        w_rout_en = 1'b1;
        if (w_op == OP_ST) begin
          w_rout_sel = w_rx;
          DOUTin     = 1'b1;
          W_D        = 1'b1;
          Done       = 1'b1;
        end else begin
          w_rout_sel = w_ry;
          Gin        = 1'b1;
          AddSub     = r_ir[OP_LSB];
          w_next     = S_X3;
        end
      end
      S_X3: begin
        if (w_op == OP_ADD || w_op == OP_SUB)
          Gout = 1'b1;
        else
          DINout = 1'b1;
        w_rin_en = 1'b1;
        Done     = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
    if (Done) w_next = Run ? S_F0 : S_IDLE;
  end

  assign Busy = (r_state != S_IDLE);

  dec3to8 u_rin_dec (
    .i_en  (w_rin_en),
    .i_sel (w_rin_sel),
    .o_dec (Rin)
  );

  dec3to8 u_rout_dec (
    .i_en  (w_rout_en),
    .i_sel (w_rout_sel),
    .o_dec (Rout)
  );

endmodule

// File: tb/tb_proc_control_fsm.sv
// Bench for proc_control_fsm: two instances (MEM_WAIT 0
// and 1) checked cycle by cycle against a sequence model.
module tb_proc_control_fsm;

  localparam logic [27:0] BSY  = 28'(1) << 0;
  localparam logic [27:0] DONE = 28'(1) << 1;
  localparam logic [27:0] INC  = 28'(1) << 2;
  localparam logic [27:0] WD   = 28'(1) << 3;
  localparam logic [27:0] DOUT = 28'(1) << 4;
  localparam logic [27:0] ADR  = 28'(1) << 5;
  localparam logic [27:0] ASUB = 28'(1) << 6;
  localparam logic [27:0] DINO = 28'(1) << 7;
  localparam logic [27:0] AIN  = 28'(1) << 8;
  localparam logic [27:0] GOUT = 28'(1) << 9;
  localparam logic [27:0] GIN  = 28'(1) << 10;
  localparam logic [27:0] IRIN = 28'(1) << 27;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run [2];
  logic [8:0] din [2];
  logic       gnz [2];
  logic       irin [2];
  logic [7:0] rin [2];
  logic [7:0] rout [2];
  logic       gin [2], gout [2], ain [2], dino [2];
  logic       asub [2], adr [2], dout [2], wd [2];
  logic       inc [2], done [2], busy [2];
  logic [27:0] obs [2];

  int tests = 0;
  int fails = 0;
  int wof [2] = '{0, 1};
  logic [27:0] exp_q [$];

  always #5 clk = ~clk;

  proc_control_fsm #(.MEM_WAIT(0)) u0 (
    .MClock(clk), .Resetn(rst), .Run(run[0]),
    .DIN(din[0]), .GNZ(gnz[0]), .IRin(irin[0]),
    .Rin(rin[0]), .Rout(rout[0]), .Gin(gin[0]),
    .Gout(gout[0]), .Ain(ain[0]), .DINout(dino[0]),
    .AddSub(asub[0]), .ADDRin(adr[0]),
    .DOUTin(dout[0]), .W_D(wd[0]), .incr_pc(inc[0]),
    .Done(done[0]), .Busy(busy[0])
  );

  proc_control_fsm #(.MEM_WAIT(1)) u1 (
    .MClock(clk), .Resetn(rst), .Run(run[1]),
    .DIN(din[1]), .GNZ(gnz[1]), .IRin(irin[1]),
    .Rin(rin[1]), .Rout(rout[1]), .Gin(gin[1]),
    .Gout(gout[1]), .Ain(ain[1]), .DINout(dino[1]),
    .AddSub(asub[1]), .ADDRin(adr[1]),
    .DOUTin(dout[1]), .W_D(wd[1]), .incr_pc(inc[1]),
    .Done(done[1]), .Busy(busy[1])
  );

  for (genvar k = 0; k < 2; k++) begin : g_obs
    assign obs[k] = {irin[k], rin[k], rout[k], gin[k],
                     gout[k], ain[k], dino[k], asub[k],
                     adr[k], dout[k], wd[k], inc[k],
                     done[k], busy[k]};
  end

  function automatic logic [27:0] ro(input logic [2:0] i);
    return 28'(1) << (11 + int'(i));
  endfunction

  function automatic logic [27:0] ri(input logic [2:0] i);
    return 28'(1) << (19 + int'(i));
  endfunction

  task automatic chk(input int k, input logic [27:0] e,
                     input string tag);
    tests++;
    assert (obs[k] === e) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%h expected=%h",
             tag, k, obs[k], e);
    end
  endtask

  // Expected per-cycle outputs of one instruction, F0..Done
  task automatic build(input logic [8:0] ir, input int w,
                       input logic g);
    logic [2:0] op, x, y;
    op = ir[8:6];
    x  = ir[5:3];
    y  = ir[2:0];
    exp_q.delete();
    exp_q.push_back(BSY | ro(7) | ADR | INC);
    repeat (w) exp_q.push_back(BSY);
    exp_q.push_back(BSY | DINO | IRIN);
    case (op)
      3'd0: exp_q.push_back(BSY | ro(y) | ri(x) | DONE);
      3'd1: begin
        exp_q.push_back(BSY | ro(7) | ADR | INC);
        repeat (w) exp_q.push_back(BSY);
        exp_q.push_back(BSY | DINO | ri(x) | DONE);
      end
      3'd2, 3'd3: begin
        exp_q.push_back(BSY | ro(x) | AIN);
        exp_q.push_back(BSY | ro(y) | GIN |
                        ((op == 3'd3) ? ASUB : 28'd0));
        exp_q.push_back(BSY | GOUT | ri(x) | DONE);
      end
      3'd4: begin
        exp_q.push_back(BSY | ro(y) | ADR);
        repeat (w) exp_q.push_back(BSY);
        exp_q.push_back(BSY | DINO | ri(x) | DONE);
      end
      3'd5: begin
        exp_q.push_back(BSY | ro(y) | ADR);
        exp_q.push_back(BSY | ro(x) | DOUT | WD | DONE);
      end
      3'd6: exp_q.push_back(BSY | DONE |
                            (g ? (ro(y) | ri(x)) : 28'd0));
      default: exp_q.push_back(BSY | DONE);
    endcase
  endtask

  task automatic start(input int k);
    @(negedge clk);
    run[k] = 1'b1;
    #1 chk(k, 28'd0, "idle_run");
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      run[k] = 1'b0;
      #1 chk(k, 28'd0, "idle");
    end
  endtask

  // drop_at: -1 keep Run, -2 drop in Done cycle, else index
  task automatic exec(input int k, input logic [8:0] ir,
                      input logic g, input int drop_at,
                      input int rst_at, input string tag);
    int n;
    int w;
    w = wof[k];
    build(ir, w, g);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din[k] = (i == 1 + w) ? ir : 9'($urandom);
      gnz[k] = g;
      run[k] = !((drop_at >= 0 && i >= drop_at) ||
                 (drop_at == -2 && i == n - 1));
      #1 chk(k, exp_q[i], tag);
      if (i == rst_at) begin
        run[k] = 1'b0;
        rst = 1'b1;
        #1 chk(k, 28'd0, "rst_async");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    run = '{1'b0, 1'b0};
    din = '{9'd0, 9'd0};
    gnz = '{1'b0, 1'b0};
    @(negedge clk);
    #1 chk(0, 28'd0, "reset0");
    chk(1, 28'd0, "reset1");
    @(negedge clk);
    rst = 1'b0;
    idle(1, 2);

    start(1);
    exec(1, 9'b001_010_000, 1'b0, -1, -1, "mvi_r2");
    exec(1, 9'b011_011_101, 1'b0, -1, -1, "sub_r3_r5");
    exec(1, 9'b110_001_100, 1'b0, -1, -1, "mvnz_g0");
    exec(1, 9'b110_001_100, 1'b1, -1, -1, "mvnz_g1");
    exec(1, 9'b000_111_011, 1'b0, -1, -1, "mv_r7");
    exec(1, 9'b111_000_000, 1'b0, -2, -1, "rsv");
    idle(1, 2);

    start(1);
    exec(1, 9'b100_011_010, 1'b0, 3, -1, "ld_drop");
    idle(1, 3);

    start(1);
    exec(1, 9'b010_001_010, 1'b0, -1, 4, "add_rst");
    idle(1, 3);

    start(0);
    exec(0, 9'b101_110_000, 1'b0, -1, -1, "st_w0");
    exec(0, 9'b001_100_000, 1'b0, -1, -1, "mvi_w0");
    exec(0, 9'b100_000_111, 1'b0, -2, -1, "ld_w0");
    idle(0, 2);

    for (int k = 0; k < 2; k++) begin
      start(k);
      for (int j = 0; j < 40; j++)
        exec(k, 9'($urandom), 1'($urandom),
             (j == 39) ? -2 : -1, -1, "rand");
      idle(k, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
